// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the instruction-bus handshake,
// and holds returned words in a registered decode slot backed by a one-entry skid.
module fetch_ctrl #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_ent_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic            slot_vld_q, slot_vld_d;
  fetch_ent_t      slot_q, slot_d;
  fetch_ent_t      skid_q, skid_d;

  logic       consumed;
  fetch_ent_t fetched;

  assign consumed = slot_vld_q && !stall;
  assign fetched  = '{instr: iresp_data, pc: pc_q};

  // While draining, the bus still owns the pre-redirect address; pc already holds the target.
  assign ireq_valid = !reset && (state_q != HOLD);
  assign ireq_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign out_valid = slot_vld_q;
  assign out_instr = slot_q.instr;
  assign out_pc    = slot_q.pc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    slot_vld_d   = slot_vld_q;
    slot_d       = slot_q;
    skid_d       = skid_q;

    if (redirect_valid) begin
      slot_vld_d = 1'b0;
      skid_d     = '0;
      pc_d       = redirect_pc;
      unique case (state_q)
        FETCH: begin
          // A same-cycle response is simply dropped; otherwise wait out the stale one.
          if (!iresp_data_ok) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end
        HOLD:    state_d = FETCH;
        DRAIN:   if (iresp_data_ok) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (iresp_data_ok) begin
            pc_d = pc_q + XLEN'(4);
            if (!slot_vld_q || consumed) begin
              slot_vld_d = 1'b1;
              slot_d     = fetched;
            end else begin
              skid_d  = fetched;
              state_d = HOLD;
            end
          end else if (consumed) begin
            slot_vld_d = 1'b0;
          end
        end
        HOLD: begin
          if (consumed) begin
            slot_vld_d = 1'b1;
            slot_d     = skid_q;
            skid_d     = '0;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (consumed)      slot_vld_d = 1'b0;
          if (iresp_data_ok) state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      drain_addr_q <= '0;
      slot_vld_q   <= 1'b0;
      slot_q       <= '0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      slot_vld_q   <= slot_vld_d;
      slot_q       <= slot_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: fixed cycle-by-cycle stimulus with hand-computed expectations.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  int vectors = 0;
  int miscompares = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ok, input logic [31:0] d, input logic st,
                       input logic rv, input logic [63:0] rpc);
    iresp_data_ok  = ok;
    iresp_data     = d;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    #1;
    chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    cyc();
    cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    cyc();

    // Basic fetch: data_ok one cycle after each request.
    do_reset();
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    #1;
    chk("t1_req0_valid", 64'(ireq_valid), 64'd1);
    chk("t1_req0_addr", ireq_addr, 64'h8000_0000);
    cyc();
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t1_out0_valid", 64'(out_valid), 64'd1);
    chk("t1_out0_pc", out_pc, 64'h8000_0000);
    chk("t1_out0_instr", 64'(out_instr), 64'h13);
    chk("t1_req1_addr", ireq_addr, 64'h8000_0004);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t1_gap_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h0010_0093, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t1_out1_pc", out_pc, 64'h8000_0004);
    chk("t1_out1_instr", 64'(out_instr), 64'h0010_0093);
    chk("t1_req2_addr", ireq_addr, 64'h8000_0008);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    cyc();
    drive(1'b1, 32'h0020_0113, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t1_out2_pc", out_pc, 64'h8000_0008);
    chk("t1_out2_instr", 64'(out_instr), 64'h0020_0113);
    chk("t1_req3_addr", ireq_addr, 64'h8000_000C);

    // Stall for 3 cycles while two responses arrive; second goes to skid.
    do_reset();
    drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
    cyc();
    chk("t2_out0_valid", 64'(out_valid), 64'd1);
    chk("t2_req1_addr", ireq_addr, 64'h8000_0004);
    drive(1'b1, 32'h0010_0093, 1'b1, 1'b0, 64'h0);
    cyc();
    chk("t2_hold_ireq", 64'(ireq_valid), 64'd0);
    chk("t2_hold_pc", out_pc, 64'h8000_0000);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    cyc();
    chk("t2_hold2_ireq", 64'(ireq_valid), 64'd0);
    chk("t2_rel_pc", out_pc, 64'h8000_0000);
    chk("t2_rel_instr", 64'(out_instr), 64'h13);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t2_skid_valid", 64'(out_valid), 64'd1);
    chk("t2_skid_pc", out_pc, 64'h8000_0004);
    chk("t2_skid_instr", 64'(out_instr), 64'h0010_0093);
    chk("t2_next_valid", 64'(ireq_valid), 64'd1);
    chk("t2_next_addr", ireq_addr, 64'h8000_0008);
    cyc();
    chk("t2_empty", 64'(out_valid), 64'd0);

    // Redirect with request outstanding; stale response arrives two cycles later.
    do_reset();
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_1000);
    cyc();
    chk("t3_drain_valid", 64'(out_valid), 64'd0);
    chk("t3_drain_addr", ireq_addr, 64'h8000_0004);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t3_drain_addr2", ireq_addr, 64'h8000_0004);
    chk("t3_drain_ireq", 64'(ireq_valid), 64'd1);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t3_discard_valid", 64'(out_valid), 64'd0);
    chk("t3_target_addr", ireq_addr, 64'h8000_1000);
    drive(1'b1, 32'h0030_0193, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t3_tgt_pc", out_pc, 64'h8000_1000);
    chk("t3_tgt_instr", 64'(out_instr), 64'h0030_0193);

    // Redirect coincident with data_ok drops the response.
    drive(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 64'h8000_3000);
    cyc();
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_ireq_addr", ireq_addr, 64'h8000_3000);
    chk("t4_ireq_valid", 64'(ireq_valid), 64'd1);

    // Two redirects during one DRAIN; only the last target is fetched.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_1000);
    cyc();
    chk("t5_drain_addr", ireq_addr, 64'h8000_3000);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_2000);
    cyc();
    chk("t5_drain_addr2", ireq_addr, 64'h8000_3000);
    drive(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t5_resume_addr", ireq_addr, 64'h8000_2000);
    chk("t5_resume_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h0040_0213, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("t5_out_pc", out_pc, 64'h8000_2000);
    chk("t5_out_instr", 64'(out_instr), 64'h0040_0213);

    // Reset mid-HOLD with a valid slot.
    drive(1'b1, 32'h0050_0293, 1'b1, 1'b0, 64'h0);
    cyc();
    chk("t6_hold_ireq", 64'(ireq_valid), 64'd0);
    chk("t6_hold_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    cyc();
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_ireq", 64'(ireq_valid), 64'd0);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    #1;
    chk("t6_restart_valid", 64'(ireq_valid), 64'd1);
    chk("t6_restart_addr", ireq_addr, 64'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer in front of the decoder. It owns the PC, drives the instruction-bus request handshake, and buffers returned instructions into a registered decode-stage slot. It handles downstream stalls and PC redirects from execute, including discarding in-flight responses for redirected fetches.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, PC loaded on reset
XLEN, 64, PC/address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ireq_valid  out  1  fetch request; held until iresp_data_ok
ireq_addr  out  XLEN  fetch address; stable while ireq_valid held
iresp_data_ok  in  1  single-cycle response strobe; completes current request
iresp_data  in  32  instruction word, valid with iresp_data_ok
stall  in  1  decode cannot accept this cycle
redirect_valid  in  1  PC redirect (branch/jump) this cycle
redirect_pc  in  XLEN  redirect target
out_valid  out  1  decode slot holds a valid instruction
out_instr  out  32  instruction to decoder
out_pc  out  XLEN  PC of out_instr

Behaviour:
- Reset (clk edge with reset=1):
  - pc=PC_RESET, state=FETCH, out_valid=0, out_instr=0, out_pc=0, skid buffer empty.
  - ireq_valid=0 while reset is high.
- Slot consumed in a cycle when out_valid && !stall.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - ireq_valid=1, ireq_addr=pc.
  - On iresp_data_ok without redirect: pc<=pc+4 (wraps mod 2^XLEN).
    - If slot empty or consumed this cycle: slot<={1,iresp_data,pc}, stay FETCH.
    - Else: skid<={iresp_data,pc}, go HOLD.
- HOLD:
  - ireq_valid=0.
  - When slot consumed: slot<=skid, skid cleared, go FETCH.
- DRAIN:
  - ireq_valid=1, ireq_addr=saved old address (stable).
  - On iresp_data_ok: response discarded, go FETCH; pc already holds target.
- Redirect (priority over stall and responses; evaluated every state):
  - out_valid<=0, skid cleared, pc<=redirect_pc.
  - FETCH with no iresp_data_ok this cycle (request outstanding): save ireq_addr, go DRAIN.
  - FETCH with iresp_data_ok same cycle: response discarded, stay FETCH; next request at redirect_pc.
  - HOLD: go FETCH.
  - DRAIN: target updated to latest redirect_pc. If iresp_data_ok arrives the same cycle, go FETCH; otherwise stay DRAIN.
- Latency:
  - iresp_data_ok in cycle N gives out_valid in N+1.
  - Next ireq_addr (pc+4) is presented in N+1; back-to-back, one instruction per cycle with a zero-wait bus.
- Invariants:
  - ireq_addr never changes while ireq_valid=1 without an intervening iresp_data_ok.
  - A discarded response never reaches out_*.
  - No instruction is lost or duplicated under stall.
- stall with out_valid=0 has no effect.
- Reset mid-request: the bus response after reset is not expected; the bus resets with the core.

Test Plan:
- Reset release, bus returns data_ok one cycle after each request with words 0x00000013, 0x00100093, 0x00200113 -> ireq_addr 0x80000000, 0x80000004, 0x80000008; out_pc/out_instr follow one cycle after each data_ok.
- stall=1 held 3 cycles while two responses arrive -> second response in skid, ireq_valid=0 during HOLD. On release, out delivers 0x80000000 then 0x80000004 in consecutive cycles; next request is 0x80000008.
- redirect_valid=1 to 0x80001000 while request to 0x80000004 is outstanding (data_ok 2 cycles later) -> ireq_addr stays 0x80000004 until data_ok; that word never appears on out_*; next request is 0x80001000; out_valid=0 in between.
- redirect in the same cycle as data_ok -> response dropped; next ireq_addr = redirect_pc the following cycle.
- Two redirects (0x80001000, then 0x80002000) during one DRAIN -> fetch resumes at 0x80002000 only.
- reset asserted mid-HOLD with out_valid=1 -> next cycle out_valid=0, ireq_valid=0; after deassert, fetch restarts at 0x80000000.
